// File: rtl/i2s_rx_ch_arbiter.sv
// Round-robin merge of per-channel I2S RX sample strobes into one tagged valid/ready
// stream, with an enable/word-count sequencer (continuous or N-word, drain on disable).
module i2s_rx_ch_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DW     = 32,
    parameter int unsigned CW     = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_en_i,
    input  logic                      cfg_continuous_i,
    input  logic [CW-1:0]             cfg_num_words_i,
    input  logic [NUM_CH*DW-1:0]      ch_data_i,
    input  logic [NUM_CH-1:0]         ch_valid_i,
    output logic [DW-1:0]             out_data_o,
    output logic [$clog2(NUM_CH)-1:0] out_ch_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [NUM_CH-1:0]         ovf_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int unsigned CHW = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   buf_v_q, buf_v_d;
    logic [DW-1:0]       buf_d_q [NUM_CH];
    logic [DW-1:0]       buf_d_d [NUM_CH];
    logic                out_valid_q, out_valid_d;
    logic [DW-1:0]       out_data_q, out_data_d;
    logic [CHW-1:0]      out_ch_q, out_ch_d;
    logic [CHW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0]   ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [DW-1:0]       ch_data [NUM_CH];
    logic [NUM_CH-1:0]   accept;
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   taken;
    logic [CHW-1:0]      scan_idx;
    logic [CHW-1:0]      sel_idx;
    logic                sel_found;
    logic [DW-1:0]       sel_data;
    logic                active;
    logic                can_load;
    logic                load;
    logic                hs;
    logic                finish;

    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            ch_data[k] = ch_data_i[k*DW +: DW];
        end
    end

    assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign accept   = (state_q == S_RUN) ? ch_valid_i : '0;
    // A push into an empty buffer competes in the same cycle, giving 1-cycle latency.
    assign req      = buf_v_q | accept;
    assign hs       = out_valid_q & out_ready_i;
    assign can_load = active && (!out_valid_q || out_ready_i);
    assign load     = can_load && sel_found;
    assign finish   = active && !cfg_continuous_i &&
                      ((cfg_num_words_i == '0) ||
                       (hs && (cnt_q == cfg_num_words_i - 1'b1)));

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            scan_idx = CHW'((32'(ptr_q) + i) % NUM_CH);
            if (!sel_found && req[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    assign sel_data = buf_v_q[sel_idx] ? buf_d_q[sel_idx] : ch_data[sel_idx];

    always_comb begin
        taken = '0;
        if (load) begin
            taken[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_v_d     = buf_v_q;
        buf_d_d     = buf_d_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;

        // {push, full, leaving}: fill, bypass, drop, reload or plain empty.
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            case ({accept[k], buf_v_q[k], taken[k]})
                3'b100: begin
                    buf_v_d[k] = 1'b1;
                    buf_d_d[k] = ch_data[k];
                end
                3'b110: ovf_d[k] = 1'b1;
                3'b111: buf_d_d[k] = ch_data[k];
                3'b011: buf_v_d[k] = 1'b0;
                default: ;
            endcase
        end

        if (can_load) begin
            out_valid_d = sel_found;
            if (sel_found) begin
                out_data_d = sel_data;
                out_ch_d   = sel_idx;
                ptr_d      = sel_idx;
            end
        end

        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                buf_v_d = '0;
                if (cfg_en_i) begin
                    state_d = S_RUN;
                    ovf_d   = '0;
                end
            end
            S_RUN, S_DRAIN: begin
                if (!cfg_continuous_i && hs) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (finish) begin
                    state_d = S_DONE;
                end else if ((state_q == S_RUN) && !cfg_en_i) begin
                    state_d = S_DRAIN;
                end else if ((state_q == S_DRAIN) && !(|buf_v_q) && !out_valid_q) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (!cfg_en_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Completion discards everything still queued.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            done_d      = 1'b1;
            buf_v_d     = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            buf_v_q     <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                buf_d_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= CHW'(NUM_CH - 1);
            cnt_q       <= '0;
            ovf_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_v_q     <= buf_v_d;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                buf_d_q[k] <= buf_d_d[k];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;
    assign out_valid_o = out_valid_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = active;
    assign done_o      = done_q;

endmodule

// File: tb/tb_i2s_rx_ch_arbiter.sv
// Bench for i2s_rx_ch_arbiter: directed scenarios plus random episodes, all checked
// every cycle against a per-channel pending-list reference model.
module tb_i2s_rx_ch_arbiter;

    localparam int NUM_CH = 4;
    localparam int DW     = 32;
    localparam int CW     = 16;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;
    localparam int S_DONE  = 3;

    logic                 clk;
    logic                 rst;
    logic                 cfg_en;
    logic                 cfg_cont;
    logic [CW-1:0]        cfg_num;
    logic [NUM_CH*DW-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_valid;
    logic [DW-1:0]        out_data;
    logic [1:0]           out_ch;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUM_CH-1:0]    ovf;
    logic                 busy;
    logic                 done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each channel keeps a list of pending words (at most one survives a cycle).
    int                m_st;
    int                occ [NUM_CH];
    logic [DW-1:0]     s0  [NUM_CH];
    logic [DW-1:0]     s1  [NUM_CH];
    bit                m_ov;
    logic [DW-1:0]     m_od;
    int                m_och;
    int                m_ptr;
    int                m_cnt;
    logic [NUM_CH-1:0] m_ovf;
    bit                m_done;

    i2s_rx_ch_arbiter #(
        .NUM_CH(NUM_CH),
        .DW    (DW),
        .CW    (CW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_en_i        (cfg_en),
        .cfg_continuous_i(cfg_cont),
        .cfg_num_words_i (cfg_num),
        .ch_data_i       (ch_data),
        .ch_valid_i      (ch_valid),
        .out_data_o      (out_data),
        .out_ch_o        (out_ch),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .ovf_o           (ovf),
        .busy_o          (busy),
        .done_o          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE;
        for (int k = 0; k < NUM_CH; k++) begin
            occ[k] = 0;
            s0[k]  = '0;
            s1[k]  = '0;
        end
        m_ov   = 1'b0;
        m_od   = '0;
        m_och  = 0;
        m_ptr  = NUM_CH - 1;
        m_cnt  = 0;
        m_ovf  = '0;
        m_done = 1'b0;
    endtask

    task automatic model_step();
        bit hs, empty0, fin, can_take;
        int win, c, nxt, num;
        if (rst) begin
            model_reset();
            return;
        end
        num    = int'(cfg_num);
        hs     = m_ov && out_ready;
        empty0 = !m_ov;
        for (int k = 0; k < NUM_CH; k++) if (occ[k] != 0) empty0 = 1'b0;
        fin = 1'b0;

        if (m_st == S_RUN) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_valid[k]) begin
                    if (occ[k] == 0) s0[k] = ch_data[k*DW +: DW];
                    else             s1[k] = ch_data[k*DW +: DW];
                    occ[k]++;
                end
            end
        end

        can_take = ((m_st == S_RUN) || (m_st == S_DRAIN)) && (!m_ov || out_ready);
        if (can_take) begin
            win = -1;
            for (int i = 1; i <= NUM_CH; i++) begin
                c = (m_ptr + i) % NUM_CH;
                if (win < 0 && occ[c] > 0) win = c;
            end
            if (win >= 0) begin
                m_od     = s0[win];
                m_och    = win;
                m_ptr    = win;
                m_ov     = 1'b1;
                s0[win]  = s1[win];
                occ[win]--;
            end else begin
                m_ov = 1'b0;
            end
        end

        for (int k = 0; k < NUM_CH; k++) begin
            if (occ[k] > 1) begin
                occ[k]   = 1;
                m_ovf[k] = 1'b1;
            end
        end

        m_done = 1'b0;
        nxt    = m_st;
        case (m_st)
            S_IDLE: begin
                m_cnt = 0;
                if (cfg_en) begin
                    nxt   = S_RUN;
                    m_ovf = '0;
                end
            end
            S_RUN, S_DRAIN: begin
                if (!cfg_cont) begin
                    fin = (num == 0) || (hs && (m_cnt == num - 1));
                    if (hs) m_cnt = (m_cnt + 1) % 65536;
                end
                if (fin)                             nxt = S_DONE;
                else if (m_st == S_RUN && !cfg_en)   nxt = S_DRAIN;
                else if (m_st == S_DRAIN && empty0)  nxt = S_IDLE;
            end
            default: if (!cfg_en) nxt = S_IDLE;
        endcase
        if (nxt == S_DONE && m_st != S_DONE) begin
            m_done = 1'b1;
            m_ov   = 1'b0;
            for (int k = 0; k < NUM_CH; k++) occ[k] = 0;
        end
        m_st = nxt;
    endtask

    task automatic compare_all();
        check("valid", out_valid, m_ov);
        check("data",  out_data,  m_od);
        check("ch",    out_ch,    m_och);
        check("ovf",   ovf,       m_ovf);
        check("busy",  busy,      (m_st == S_RUN) || (m_st == S_DRAIN));
        check("done",  done,      m_done);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_push(input int k, input logic [DW-1:0] val);
        ch_valid[k]          = 1'b1;
        ch_data[k*DW +: DW]  = val;
    endtask

    task automatic clear_push();
        ch_valid = '0;
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < NUM_CH; k++) begin
            ch_valid[k]         = ($urandom_range(0, 9) < 4);
            ch_data[k*DW +: DW] = $urandom;
        end
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        cfg_en    = 1'b0;
        ch_valid  = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        model_reset();
        #1;
        compare_all();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input bit rnd);
        int guard;
        guard = 0;
        while (m_st != S_IDLE && guard < max_cycles) begin
            if (rnd) rand_inputs();
            tick();
            guard++;
        end
        check("idle_timeout", guard < max_cycles, 1);
        clear_push();
    endtask

    initial begin
        int hs_cnt, done_cnt, len, rst_at, guard;
        rst       = 1'b1;
        cfg_en    = 1'b0;
        cfg_cont  = 1'b1;
        cfg_num   = '0;
        ch_data   = '0;
        ch_valid  = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset values and first-push latency
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_data",  out_data,  0);
        check("rst_ovf",   ovf,       0);
        check("rst_busy",  busy,      0);
        cfg_en = 1'b1;
        tick();
        set_push(2, 32'hA5A5_0002);
        tick();
        clear_push();
        check("lat_valid", out_valid, 1);
        check("lat_data",  out_data,  32'hA5A5_0002);
        check("lat_ch",    out_ch,    2);

        // Round-robin: two bursts on all channels
        do_reset();
        cfg_cont = 1'b1;
        cfg_en   = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NUM_CH; k++) set_push(k, 32'h10 + 32'(b * 16 + k));
            tick();
            clear_push();
            for (int k = 0; k < NUM_CH; k++) begin
                check("rr_ch",   out_ch,   k);
                check("rr_data", out_data, 32'h10 + 32'(b * 16 + k));
                tick();
            end
        end
        check("rr_empty", out_valid, 0);

        // Back-pressure and overflow on ch1
        out_ready = 1'b0;
        set_push(1, 32'h1); tick();
        set_push(1, 32'h2); tick();
        check("bp_hold", out_data, 32'h1);
        set_push(1, 32'h3); tick();
        clear_push();
        check("ovf_ch1", ovf, 4'b0010);
        out_ready = 1'b1;
        tick();
        check("bp_second", out_data, 32'h2);
        tick();
        check("bp_empty", out_valid, 0);

        // Same-cycle drain and push on ch0
        out_ready = 1'b0;
        set_push(0, 32'hA); tick();
        set_push(0, 32'hB); tick();
        out_ready = 1'b1;
        set_push(0, 32'hC); tick();
        clear_push();
        check("same_ovf0", ovf[0], 0);
        check("same_b",    out_data, 32'hB);
        tick();
        check("same_c",    out_data, 32'hC);
        tick();

        // N-word transfer of 5
        cfg_en = 1'b0;
        wait_idle(100, 1'b0);
        out_ready = 1'b1;
        cfg_cont  = 1'b0;
        cfg_num   = 16'd5;
        cfg_en    = 1'b1;
        tick();
        hs_cnt   = 0;
        done_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 8) set_push(i % NUM_CH, 32'h100 + 32'(i));
            if (out_valid && out_ready) hs_cnt++;
            tick();
            clear_push();
            if (done) done_cnt++;
        end
        check("nw_hs",    hs_cnt,   5);
        check("nw_done",  done_cnt, 1);
        check("nw_valid", out_valid, 0);
        cfg_en = 1'b0;
        tick();
        tick();
        check("nw_busy", busy, 0);

        // Disable drain: three buffered words, toggling ready
        cfg_cont  = 1'b1;
        cfg_en    = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) set_push(k, 32'h200 + 32'(k));
        tick();
        clear_push();
        cfg_en = 1'b0;
        hs_cnt = 0;
        guard  = 0;
        while (m_st != S_IDLE && guard < 60) begin
            out_ready = guard[0];
            if (m_st == S_DRAIN) set_push(3, $urandom);
            if (out_valid && out_ready) hs_cnt++;
            tick();
            clear_push();
            guard++;
        end
        check("drain_timeout", guard < 60, 1);
        check("drain_hs", hs_cnt, 3);

        // Reset in the middle of a drain
        cfg_en = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) set_push(k, 32'h300 + 32'(k));
        tick();
        clear_push();
        cfg_en = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_mid_valid", out_valid, 0);
        compare_all();
        tick();
        rst = 1'b0;

        // Random episodes
        for (int ep = 0; ep < 60; ep++) begin
            cfg_en = 1'b0;
            wait_idle(300, 1'b1);
            cfg_cont = $urandom_range(0, 1);
            cfg_num  = 16'($urandom_range(0, 6));
            cfg_en   = 1'b1;
            len      = $urandom_range(4, 40);
            rst_at   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len - 1) : -1;
            for (int cyc = 0; cyc < len; cyc++) begin
                if (cyc == rst_at) begin
                    do_reset();
                    break;
                end
                if (m_st == S_DONE) cfg_en = 1'b0;
                rand_inputs();
                tick();
            end
            cfg_en = 1'b0;
            wait_idle(300, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
